// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the multi-cycle divider: latches operands, drives the
// divider handshake, stalls the pipeline and delivers the HI/LO write.
module div_issue_ctrl #(
  parameter int TIMEOUT      = 64,
  parameter int ABORT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req_i,
  input  logic        div_signed_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        timeout_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i
);

  localparam int WCW = $clog2(TIMEOUT) + 1;
  localparam int ACW = $clog2(ABORT_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_start;
  logic            r_annul;
  logic            r_signed;
  logic [31:0]     r_op1;
  logic [31:0]     r_op2;
  logic            r_timeout;
  logic [WCW-1:0]  r_wait_cnt;
  logic [ACW-1:0]  r_abort_cnt;

  logic            w_stall;
  logic            w_we;

  // Handshake FSM; annul and timeout default low so each is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_start     <= 1'b0;
      r_annul     <= 1'b0;
      r_signed    <= 1'b0;
      r_op1       <= 32'h0;
      r_op2       <= 32'h0;
      r_timeout   <= 1'b0;
      r_wait_cnt  <= '0;
      r_abort_cnt <= '0;
    end else begin
      r_annul   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (div_req_i && !flush_i) begin
            r_op1      <= op1_i;
            r_op2      <= op2_i;
            r_signed   <= div_signed_i;
            r_start    <= 1'b1;
            r_wait_cnt <= '0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + WCW'(1);
          if (flush_i) begin
            r_annul     <= 1'b1;
            r_start     <= 1'b0;
            r_abort_cnt <= '0;
            r_state     <= S_ABORT;
          end else if (div_ready_i) begin
            r_start <= 1'b0;
            r_state <= S_DONE;
          end else if (r_wait_cnt == WCW'(TIMEOUT - 1)) begin
            r_annul     <= 1'b1;
            r_start     <= 1'b0;
            r_timeout   <= 1'b1;
            r_abort_cnt <= '0;
            r_state     <= S_ABORT;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        S_ABORT: begin
          if (r_abort_cnt == ACW'(ABORT_CYCLES - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_abort_cnt <= r_abort_cnt + ACW'(1);
          end
        end
        default: begin
          r_start <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Pipeline-facing stall and HI/LO write; flush beats a coincident ready.
  always_comb begin
    w_stall = 1'b0;
    w_we    = 1'b0;
    case (r_state)
      S_IDLE:  w_stall = div_req_i & ~flush_i;
      S_WAIT: begin
        if (flush_i) begin
          w_stall = 1'b0;
          w_we    = 1'b0;
        end else if (div_ready_i) begin
          w_stall = 1'b0;
          w_we    = 1'b1;
        end else begin
          w_stall = 1'b1;
          w_we    = 1'b0;
        end
      end
      S_DONE:  w_stall = div_req_i;
      S_ABORT: w_stall = div_req_i & ~flush_i;
      default: w_stall = 1'b0;
    endcase
  end

  assign stall_o       = w_stall;
  assign hilo_we_o     = w_we;
  assign hi_o          = w_we ? div_result_i[63:32] : 32'h0;
  assign lo_o          = w_we ? div_result_i[31:0]  : 32'h0;
  assign timeout_o     = r_timeout;
  assign div_start_o   = r_start;
  assign div_annul_o   = r_annul;
  assign div_signed_o  = r_signed;
  assign div_opdata1_o = r_op1;
  assign div_opdata2_o = r_op2;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural divider and a HI/LO scoreboard.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        div_req_i = 1'b0;
  logic        div_signed_i = 1'b0;
  logic [31:0] op1_i = 32'h0;
  logic [31:0] op2_i = 32'h0;
  logic        flush_i = 1'b0;
  logic        stall_o, hilo_we_o, timeout_o;
  logic [31:0] hi_o, lo_o;
  logic        div_start_o, div_annul_o, div_signed_o;
  logic [31:0] div_opdata1_o, div_opdata2_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;

  int          tests = 0;
  int          fails = 0;
  int          writes = 0;
  int          tmo_cnt = 0;
  bit          stuck = 1'b0;
  logic [63:0] exp_q[$];

  div_issue_ctrl #(.TIMEOUT(64), .ABORT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .div_req_i(div_req_i), .div_signed_i(div_signed_i),
    .op1_i(op1_i), .op2_i(op2_i), .flush_i(flush_i), .stall_o(stall_o),
    .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o), .timeout_o(timeout_o),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
    .div_opdata1_o(div_opdata1_o), .div_opdata2_o(div_opdata2_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] div_calc(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'h0) return 64'h0;
    if (s) begin
      sa = a; sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {sr, sq};
    end
    return {a % b, a / b};
  endfunction

  // Divider model: 36-cycle result for a nonzero divisor, short path for zero, ready held until start drops.
  logic       m_busy;
  logic [5:0] m_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_cnt <= 6'd0; div_ready_i <= 1'b0; div_result_i <= 64'h0;
    end else if (div_annul_o || !div_start_o) begin
      m_busy <= 1'b0; div_ready_i <= 1'b0;
    end else if (!m_busy && !div_ready_i) begin
      m_busy       <= 1'b1;
      m_cnt        <= (div_opdata2_o == 32'h0) ? 6'd2 : 6'd34;
      div_result_i <= div_calc(div_signed_o, div_opdata1_o, div_opdata2_o);
    end else if (m_busy && !stuck) begin
      if (m_cnt == 6'd0) begin
        m_busy <= 1'b0; div_ready_i <= 1'b1;
      end else begin
        m_cnt <= m_cnt - 6'd1;
      end
    end
  end

  // Scoreboard: every HI/LO write pops the oldest expected result.
  always @(negedge clk) begin
    if (rst) begin
      if (timeout_o) tmo_cnt++;
      if (hilo_we_o) begin
        writes++;
        if (exp_q.size() == 0) check("unexpected_write", 64'(hilo_we_o), 64'd0);
        else check("hilo_result", {hi_o, lo_o}, exp_q.pop_front());
      end
    end
  end

  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit hold_req, output int cyc);
    bit got, gap, sgn_ok;
    @(posedge clk); #1;
    div_req_i = 1'b1; div_signed_i = s; op1_i = a; op2_i = b;
    exp_q.push_back(exp);
    got = 1'b0; gap = 1'b0; sgn_ok = 1'b1; cyc = 0;
    while (!got && cyc < 200) begin
      @(negedge clk); cyc++;
      if (hilo_we_o) got = 1'b1;
      else begin
        if (!stall_o) gap = 1'b1;
        if (cyc > 1 && div_signed_o !== s) sgn_ok = 1'b0;
      end
    end
    check("write_seen", 64'(got), 64'd1);
    check("stall_in_write", 64'(stall_o), 64'd0);
    check("stall_before_write", 64'(gap), 64'd0);
    check("signed_flag_held", 64'(sgn_ok), 64'd1);
    @(posedge clk); #1;
    if (!hold_req) div_req_i = 1'b0;
    @(negedge clk);
    check("done_start_low", 64'(div_start_o), 64'd0);
    check("done_stall", 64'(stall_o), 64'(hold_req));
  endtask

  initial begin
    int cyc, n, w0;
    bit stall_ok;

    repeat (2) @(posedge clk);
    #1;
    check("rst_start", 64'(div_start_o), 64'd0);
    check("rst_annul", 64'(div_annul_o), 64'd0);
    check("rst_signed", 64'(div_signed_o), 64'd0);
    check("rst_ops", {div_opdata1_o, div_opdata2_o}, 64'd0);
    check("rst_timeout", 64'(timeout_o), 64'd0);
    check("rst_hilo", {31'd0, hilo_we_o, hi_o, lo_o}, 64'd0);
    check("rst_stall", 64'(stall_o), 64'd0);
    rst = 1'b1;

    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, cyc);
    check("latency_100_7", 64'(cyc >= 30 && cyc <= 45), 64'd1);

    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, cyc);

    run_div(1'b0, 32'd5, 32'd0, 64'd0, 1'b0, cyc);
    check("latency_div0", 64'(cyc <= 8), 64'd1);
    check("no_timeout_div0", 64'(tmo_cnt), 64'd0);

    // Flush in WAIT cycle 10.
    @(posedge clk); #1;
    div_req_i = 1'b1; div_signed_i = 1'b0; op1_i = 32'd50; op2_i = 32'd5;
    repeat (10) @(posedge clk);
    #1 flush_i = 1'b1;
    w0 = writes;
    @(negedge clk);
    check("flush_stall", 64'(stall_o), 64'd0);
    check("flush_no_we", 64'(hilo_we_o), 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0; div_req_i = 1'b0;
    @(negedge clk);
    check("abort1_annul", 64'(div_annul_o), 64'd1);
    check("abort1_start", 64'(div_start_o), 64'd0);
    @(negedge clk);
    check("abort2_annul", 64'(div_annul_o), 64'd0);
    check("abort2_start", 64'(div_start_o), 64'd0);
    @(negedge clk);
    check("flush_no_write", 64'(writes), 64'(w0));
    run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, cyc);

    run_div(1'b0, 32'd10, 32'd3, {32'd1, 32'd3}, 1'b1, cyc);
    run_div(1'b0, 32'd20, 32'd6, {32'd2, 32'd3}, 1'b0, cyc);

    // Stuck divider: timeout, then re-issue, then asynchronous reset mid-WAIT.
    stuck = 1'b1;
    @(posedge clk); #1;
    div_req_i = 1'b1; div_signed_i = 1'b0; op1_i = 32'd8; op2_i = 32'd2;
    n = 0; stall_ok = 1'b1;
    while (!timeout_o && n < 200) begin
      @(negedge clk); n++;
      if (!stall_o) stall_ok = 1'b0;
    end
    check("timeout_cycle", 64'(n), 64'd66);
    check("timeout_stall_held", 64'(stall_ok), 64'd1);
    check("timeout_annul", 64'(div_annul_o), 64'd1);
    check("timeout_start_low", 64'(div_start_o), 64'd0);
    @(negedge clk);
    check("timeout_pulse_width", 64'(timeout_o), 64'd0);
    check("timeout_annul_width", 64'(div_annul_o), 64'd0);
    n = 0;
    while (!div_start_o && n < 20) begin
      @(negedge clk); n++;
    end
    check("reissue_start", 64'(div_start_o), 64'd1);
    check("reissue_ops", {div_opdata1_o, div_opdata2_o}, {32'd8, 32'd2});
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b0; div_req_i = 1'b0;
    #1;
    check("arst_start", 64'(div_start_o), 64'd0);
    check("arst_annul_tmo", {62'd0, div_annul_o, timeout_o}, 64'd0);
    check("arst_signed", 64'(div_signed_o), 64'd0);
    check("arst_ops", {div_opdata1_o, div_opdata2_o}, 64'd0);
    check("arst_comb", {30'd0, stall_o, hilo_we_o, hi_o | lo_o}, 64'd0);
    check("timeout_count", 64'(tmo_cnt), 64'd1);
    stuck = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("write_count", 64'(writes), 64'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
